swipt_drive_gen: RTL and testbench

Drives the SWIPT power-stage half bridge at the frequency requested by the frequency-search logic. It converts the 20-bit requested frequency (Hz) into a half-period cycle count using a sequential divider. It then generates complementary gate signals with dead time. New frequencies are applied only at full-period boundaries, so the bridge is never glitched, and each applied change is reported with a one-cycle pulse.

---
 rtl/swipt_drive_gen.sv | 191 +++++++++++++++++++
 tb/tb_swipt_drive_gen.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/swipt_drive_gen.sv
// Half-bridge gate driver for the SWIPT power stage: converts a requested frequency
// into a half-period via a restoring divider and drives complementary gates with dead time.
module swipt_drive_gen #(
    parameter int unsigned CLK_HZ      = 100000000,
    parameter int unsigned DEAD_CYCLES = 5,
    parameter int unsigned FREQ_MIN    = 10000,
    parameter int unsigned FREQ_MAX    = 1000000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        enable,
    input  logic [19:0] freq_in,
    output logic        gate_h,
    output logic        gate_l,
    output logic        freq_busy,
    output logic        freq_applied,
    output logic [19:0] active_freq,
    output logic [23:0] half_period
);

    typedef enum logic [1:0] {S_OFF, S_DIV, S_RUN, S_PEND} state_t;

    localparam logic [31:0] DVD   = 32'(CLK_HZ);
    localparam logic [19:0] FMIN  = 20'(FREQ_MIN);
    localparam logic [19:0] FMAX  = 20'(FREQ_MAX);
    localparam logic [23:0] DEAD  = 24'(DEAD_CYCLES);

    state_t      state_q, state_d;
    logic [19:0] tgt_q, tgt_d;
    logic [20:0] rem_q, rem_d;
    logic [23:0] quo_q, quo_d;
    logic [4:0]  div_cnt_q, div_cnt_d;
    logic        phase_q, phase_d;      // 0 = H half, 1 = L half
    logic [23:0] cnt_q, cnt_d;
    logic [23:0] hp_q, hp_d;
    logic [19:0] act_q, act_d;
    logic        gate_h_q, gate_h_d;
    logic        gate_l_q, gate_l_d;
    logic        busy_q, busy_d;
    logic        applied_q, applied_d;

    logic [19:0] req;
    logic [4:0]  bit_idx;
    logic        dvd_bit;
    logic [20:0] divisor;
    logic [21:0] rem_sh;
    logic        ge;
    logic [20:0] rem_step;
    logic [23:0] quo_step;
    logic        running;
    logic        last_cnt;
    logic        boundary;

    assign req = (freq_in < FMIN) ? FMIN : ((freq_in > FMAX) ? FMAX : freq_in);

    // One restoring-division step; the quotient upper bits are always zero under
    // the parameter constraints, so only 24 bits are kept.
    assign bit_idx  = 5'd31 - div_cnt_q;
    assign dvd_bit  = DVD[bit_idx];
    assign divisor  = {tgt_q, 1'b0};
    assign rem_sh   = {rem_q, dvd_bit};
    assign ge       = rem_sh >= {1'b0, divisor};
    assign rem_step = ge ? (rem_sh[20:0] - divisor) : rem_sh[20:0];
    assign quo_step = {quo_q[22:0], ge};

    assign running  = hp_q != 24'd0;
    assign last_cnt = cnt_q == (hp_q - 24'd1);
    assign boundary = running && last_cnt && phase_q;

    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_cnt_d = div_cnt_q;
        hp_d      = hp_q;
        act_d     = act_q;
        applied_d = 1'b0;
        phase_d   = 1'b0;
        cnt_d     = 24'd0;
        if (running) begin
            cnt_d   = last_cnt ? 24'd0 : cnt_q + 24'd1;
            phase_d = last_cnt ? ~phase_q : phase_q;
        end

        case (state_q)
            S_OFF: begin
                hp_d  = 24'd0;
                act_d = 20'd0;
                if (enable) begin
                    tgt_d     = req;
                    rem_d     = 21'd0;
                    quo_d     = 24'd0;
                    div_cnt_d = 5'd0;
                    state_d   = S_DIV;
                end
            end
            S_DIV: begin
                rem_d     = rem_step;
                quo_d     = quo_step;
                div_cnt_d = div_cnt_q + 5'd1;
                if (div_cnt_q == 5'd31) begin
                    if (!running) begin
                        hp_d      = quo_step;
                        act_d     = tgt_q;
                        applied_d = 1'b1;
                        cnt_d     = 24'd0;
                        phase_d   = 1'b0;
                        state_d   = S_RUN;
                    end else begin
                        state_d = S_PEND;
                    end
                end
            end
            S_RUN: begin
                if (req != tgt_q) begin
                    tgt_d     = req;
                    rem_d     = 21'd0;
                    quo_d     = 24'd0;
                    div_cnt_d = 5'd0;
                    state_d   = S_DIV;
                end
            end
            S_PEND: begin
                if (boundary) begin
                    hp_d      = quo_q;
                    act_d     = tgt_q;
                    applied_d = 1'b1;
                    cnt_d     = 24'd0;
                    phase_d   = 1'b0;
                    state_d   = S_RUN;
                end
            end
            default: state_d = S_OFF;
        endcase

        // Disable overrides everything, including a coincident apply.
        if (!enable) begin
            state_d   = S_OFF;
            hp_d      = 24'd0;
            act_d     = 20'd0;
            applied_d = 1'b0;
            cnt_d     = 24'd0;
            phase_d   = 1'b0;
        end

        gate_h_d = (hp_d != 24'd0) && !phase_d && (cnt_d >= DEAD);
        gate_l_d = (hp_d != 24'd0) &&  phase_d && (cnt_d >= DEAD);
        busy_d   = (state_d == S_DIV) || (state_d == S_PEND);
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= S_OFF;
            tgt_q     <= 20'd0;
            rem_q     <= 21'd0;
            quo_q     <= 24'd0;
            div_cnt_q <= 5'd0;
            phase_q   <= 1'b0;
            cnt_q     <= 24'd0;
            hp_q      <= 24'd0;
            act_q     <= 20'd0;
            gate_h_q  <= 1'b0;
            gate_l_q  <= 1'b0;
            busy_q    <= 1'b0;
            applied_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            div_cnt_q <= div_cnt_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            hp_q      <= hp_d;
            act_q     <= act_d;
            gate_h_q  <= gate_h_d;
            gate_l_q  <= gate_l_d;
            busy_q    <= busy_d;
            applied_q <= applied_d;
        end
    end

    assign gate_h       = gate_h_q;
    assign gate_l       = gate_l_q;
    assign freq_busy    = busy_q;
    assign freq_applied = applied_q;
    assign active_freq  = act_q;
    assign half_period  = hp_q;

endmodule

// File: tb/tb_swipt_drive_gen.sv
// Scoreboard bench for swipt_drive_gen: expected applies are queued by the stimulus,
// a monitor pops and compares on every freq_applied pulse.
module tb_swipt_drive_gen;

    logic        clk = 1'b0;
    logic        nrst;
    logic        enable;
    logic [19:0] freq_in;
    logic        gate_h, gate_l, freq_busy, freq_applied;
    logic [19:0] active_freq;
    logic [23:0] half_period;

    swipt_drive_gen dut (
        .clk          (clk),
        .nrst         (nrst),
        .enable       (enable),
        .freq_in      (freq_in),
        .gate_h       (gate_h),
        .gate_l       (gate_l),
        .freq_busy    (freq_busy),
        .freq_applied (freq_applied),
        .active_freq  (active_freq),
        .half_period  (half_period)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] f;
        logic [23:0] hp;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   apply_cnt = 0;
    bit   overlap_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (gate_h && gate_l) overlap_seen = 1;
        if (freq_applied) begin
            apply_cnt++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_apply: got freq=%0d hp=%0d required no apply",
                         active_freq, half_period);
            end else begin
                mon_e = sb.pop_front();
                $display("apply freq=%0d hp=%0d (expected freq=%0d hp=%0d)",
                         active_freq, half_period, mon_e.f, mon_e.hp);
                check("apply_freq", 32'(active_freq), 32'(mon_e.f));
                check("apply_hp", 32'(half_period), 32'(mon_e.hp));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [19:0] f, input logic [23:0] hp);
        exp_t e;
        e.f  = f;
        e.hp = hp;
        sb.push_back(e);
    endtask

    // Ticks until freq_applied is seen; counts busy and gate_h samples along the way.
    task automatic wait_apply(input int bound, output int k, output int nbusy, output int nh);
        k = 0; nbusy = 0; nh = 0;
        do begin
            tick();
            k++;
            if (freq_busy) nbusy++;
            if (gate_h) nh++;
        end while (!freq_applied && k < bound);
        if (!freq_applied) begin
            total++;
            bad++;
            $display("FAIL apply_timeout: got no apply after %0d cycles required an apply", k);
        end
    endtask

    // Samples the current cycle plus n-1 further cycles.
    task automatic count_gates(input int n, output int h, output int l, output int b,
                               output int fh, output int fl);
        h = 0; l = 0; b = 0; fh = -1; fl = -1;
        for (int i = 0; i < n; i++) begin
            if (i != 0) tick();
            if (gate_h) begin h++; if (fh < 0) fh = i; end
            if (gate_l) begin l++; if (fl < 0) fl = i; end
            if (freq_busy) b++;
        end
    endtask

    task automatic check_off(input string tag);
        check({tag, "_gate_h"}, 32'(gate_h), 32'd0);
        check({tag, "_gate_l"}, 32'(gate_l), 32'd0);
        check({tag, "_busy"}, 32'(freq_busy), 32'd0);
        check({tag, "_applied"}, 32'(freq_applied), 32'd0);
        check({tag, "_active"}, 32'(active_freq), 32'd0);
        check({tag, "_hp"}, 32'(half_period), 32'd0);
    endtask

    initial begin
        int k, nb, nh, h, l, b, fh, fl, a0;
        nrst = 1'b0; enable = 1'b0; freq_in = 20'd0;
        repeat (3) tick();
        nrst = 1'b1;
        tick();
        check_off("reset");

        // 1: start from OFF at 500 kHz
        freq_in = 20'd500000; enable = 1'b1;
        push(20'd500000, 24'd100);
        wait_apply(100, k, nb, nh);
        check("t1_latency", 32'(k), 32'd33);
        check("t1_busy_cycles", 32'(nb), 32'd32);
        count_gates(200, h, l, b, fh, fl);
        check("t1_h_cycles", 32'(h), 32'd95);
        check("t1_l_cycles", 32'(l), 32'd95);
        check("t1_h_first", 32'(fh), 32'd5);
        check("t1_l_first", 32'(fl), 32'd105);

        // 2: retune to 1 MHz while running; old period must finish first
        a0 = apply_cnt;
        freq_in = 20'd1000000;
        push(20'd1000000, 24'd50);
        wait_apply(400, k, nb, nh);
        check("t2_wait", 32'(k), 32'd201);
        check("t2_busy_cycles", 32'(nb), 32'd200);
        check("t2_old_h_cycles", 32'(nh), 32'd95);
        count_gates(100, h, l, b, fh, fl);
        check("t2_h_cycles", 32'(h), 32'd45);
        check("t2_l_cycles", 32'(l), 32'd45);
        check("t2_l_first", 32'(fl), 32'd55);
        check("t2_apply_count", 32'(apply_cnt), 32'(a0 + 1));

        // 3: clamping at both ends
        freq_in = 20'd0;
        push(20'd10000, 24'd5000);
        wait_apply(500, k, nb, nh);
        check("t3_min_wait", 32'(k), 32'd101);
        freq_in = 20'hFFFFF;
        push(20'd1000000, 24'd50);
        wait_apply(12000, k, nb, nh);
        check("t3_max_wait", 32'(k), 32'd10000);

        // 4: drop enable mid-H, then re-enable at 250 kHz
        repeat (20) tick();
        check("t4_gate_h_mid", 32'(gate_h), 32'd1);
        enable = 1'b0;
        tick();
        check_off("t4_off");
        freq_in = 20'd250000; enable = 1'b1;
        push(20'd250000, 24'd200);
        wait_apply(100, k, nb, nh);
        check("t4_latency", 32'(k), 32'd33);

        // 5: freq_in wiggles during DIV; only one apply, no re-divide
        enable = 1'b0;
        tick();
        freq_in = 20'd500000; enable = 1'b1;
        push(20'd500000, 24'd100);
        a0 = apply_cnt;
        repeat (3) tick();
        freq_in = 20'd800000;
        repeat (5) tick();
        freq_in = 20'd500000;
        wait_apply(100, k, nb, nh);
        check("t5_latency", 32'(k), 32'd25);
        count_gates(300, h, l, b, fh, fl);
        check("t5_busy_after", 32'(b), 32'd0);
        check("t5_h_cycles", 32'(h), 32'd190);
        check("t5_apply_count", 32'(apply_cnt), 32'(a0 + 1));

        // 6a: reset mid-DIV
        freq_in = 20'd1000000;
        push(20'd1000000, 24'd50);
        repeat (10) tick();
        check("t6a_busy", 32'(freq_busy), 32'd1);
        nrst = 1'b0;
        sb.delete();
        a0 = apply_cnt;
        tick();
        check_off("t6a_rst");
        nrst = 1'b1;
        push(20'd1000000, 24'd50);
        wait_apply(100, k, nb, nh);
        check("t6a_latency", 32'(k), 32'd33);
        check("t6a_apply_count", 32'(apply_cnt), 32'(a0 + 1));

        // 6b: reset mid-PEND
        freq_in = 20'd500000;
        push(20'd500000, 24'd100);
        repeat (40) tick();
        check("t6b_busy", 32'(freq_busy), 32'd1);
        check("t6b_hp_old", 32'(half_period), 32'd50);
        nrst = 1'b0;
        sb.delete();
        a0 = apply_cnt;
        tick();
        check_off("t6b_rst");
        check("t6b_no_apply", 32'(apply_cnt), 32'(a0));
        nrst = 1'b1;
        push(20'd500000, 24'd100);
        wait_apply(100, k, nb, nh);
        check("t6b_latency", 32'(k), 32'd33);

        repeat (5) tick();
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("no_overlap", 32'(overlap_seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
